// File: rtl/dfc_param.sv
// rtl/dfc_param.sv - parametrised data-flow controller: sample buffer with streamed pair results
//
// Purpose:
//   Loads DEPTH samples of DATA_W bits, then streams PAIRS = DEPTH/2 results,
//   where pair k = f(sample k, sample k+PAIRS). Results come out in ascending k
//   (FIFO) or descending k (LIFO) order. The pair operation is chosen per
//   output command. Commands arriving while busy are dropped.
//
// Optional feature macro: DFC_ERR_EN (adds the err output).
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   datain        in   [DATA_W-1:0] sample data, captured during LOAD
//   cmd           in   [1:0] 00 LOAD, 01 FIFO out, 10 LIFO out, 11 CLEAR
//   cmd_valid     in   command strobe
//   op            in   [1:0] 00 add, 01 sub, 10 max, 11 absdiff (latched with FIFO/LIFO)
//   dataout       out  [DATA_W:0] result, 0 when output_valid=0
//   output_valid  out  dataout qualifier
//   busy          out  1 = commands are ignored
//   err           out  (DFC_ERR_EN only) one-cycle pulse on a rejected or dropped command

module dfc_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [1:0]        cmd,
  input  logic              cmd_valid,
  input  logic [1:0]        op,
  output logic [DATA_W:0]   dataout,
  output logic              output_valid,
  output logic              busy
`ifdef DFC_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int PAIRS = DEPTH / 2;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_OUT   = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              loaded_q, loaded_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              lifo_q, lifo_d;
  logic [DATA_W:0]   dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
`ifdef DFC_ERR_EN
  logic              err_q, err_d;
`endif

  // Result selection for the cycle being registered.
  logic              emit;
  logic [1:0]        emit_op;
  logic              emit_lifo;
  logic [IW-1:0]     emit_idx;
  logic [IW-1:0]     k_a;
  logic [IW-1:0]     k_b;

  function automatic logic [DATA_W:0] pair_op(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [1:0]        sel);
    logic [DATA_W:0] ae;
    logic [DATA_W:0] be;
    ae = {1'b0, a};
    be = {1'b0, b};
    case (sel)
      2'b00:   return ae + be;
      2'b01:   return ae - be;
      2'b10:   return (a > b) ? ae : be;
      default: return (a > b) ? (ae - be) : (be - ae);
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    loaded_d  = loaded_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    lifo_d    = lifo_q;
    dout_d    = '0;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    emit      = 1'b0;
    emit_op   = op_q;
    emit_lifo = lifo_q;
    emit_idx  = cnt_q[IW-1:0];
`ifdef DFC_ERR_EN
    err_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd)
            2'b00: begin
              state_d = S_LOAD;
              cnt_d   = '0;
              busy_d  = 1'b1;
            end
            2'b01, 2'b10: begin
              if (loaded_q) begin
                // The first result is produced straight from the command
                // inputs so it is visible in the cycle after acceptance.
                state_d   = S_OUT;
                op_d      = op;
                lifo_d    = cmd[1];
                emit      = 1'b1;
                emit_op   = op;
                emit_lifo = cmd[1];
                emit_idx  = '0;
                cnt_d     = CW'(1);
                busy_d    = 1'b1;
              end else begin
`ifdef DFC_ERR_EN
                err_d = 1'b1;
`endif
              end
            end
            default: begin
              state_d = S_CLEAR;
              busy_d  = 1'b1;
            end
          endcase
        end
      end

      S_LOAD: begin
        mem_d[cnt_q[IW-1:0]] = datain;
        if (cnt_q == CW'(DEPTH - 1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          loaded_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`ifdef DFC_ERR_EN
        err_d = cmd_valid;
`endif
      end

      S_OUT: begin
        // cnt_q counts results already emitted; once all are out, this
        // cycle is the last busy one.
        if (cnt_q == CW'(PAIRS)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          emit  = 1'b1;
          cnt_d = cnt_q + CW'(1);
        end
`ifdef DFC_ERR_EN
        err_d = cmd_valid;
`endif
      end

      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_d[i] = '0;
        end
        loaded_d = 1'b0;
        state_d  = S_IDLE;
        busy_d   = 1'b0;
`ifdef DFC_ERR_EN
        err_d = cmd_valid;
`endif
      end
    endcase

    k_a = emit_lifo ? (IW'(PAIRS - 1) - emit_idx) : emit_idx;
    k_b = k_a + IW'(PAIRS);
    if (emit) begin
      dout_d  = pair_op(mem_q[k_a], mem_q[k_b], emit_op);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      loaded_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      lifo_q   <= 1'b0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DFC_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      lifo_q   <= lifo_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef DFC_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  assign dataout      = dout_q;
  assign output_valid = valid_q;
  assign busy         = busy_q;
`ifdef DFC_ERR_EN
  assign err          = err_q;
`endif

endmodule

// File: tb/tb_dfc_param.sv
// tb/tb_dfc_param.sv - self-checking bench for dfc_param (DATA_W=8, DEPTH=8)

module tb_dfc_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] datain;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic [1:0] op;
  logic [8:0] dataout;
  logic       output_valid;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dfc_param #(.DATA_W(8), .DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .datain       (datain),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .op           (op),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // ld: data set to load (0 = no load); lpoke: cycles of the load that see a
  // stray cmd_valid; bpoke: same for the output burst; pcmd: stray command.
  typedef struct {
    int              ld;
    logic [7:0]      lpoke;
    logic [1:0]      c;
    logic [1:0]      o;
    logic [3:0][8:0] e;
    logic [3:0]      bpoke;
    logic [1:0]      pcmd;
  } vec_t;

  vec_t vt [9];

  function automatic vec_t mk(input int ld, input logic [7:0] lpoke,
                              input logic [1:0] c, input logic [1:0] o,
                              input logic [8:0] e0, input logic [8:0] e1,
                              input logic [8:0] e2, input logic [8:0] e3,
                              input logic [3:0] bpoke, input logic [1:0] pcmd);
    vec_t v;
    v.ld = ld; v.lpoke = lpoke; v.c = c; v.o = o;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    v.bpoke = bpoke; v.pcmd = pcmd;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] sample(input int sel, input int i);
    logic [7:0] a [8];
    a = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd1, 8'd2, 8'd3, 8'd4};
    case (sel)
      1:       return a[i];
      2:       return (i < 4) ? 8'd0 : 8'd255;
      default: return 8'd255;
    endcase
  endfunction

  task automatic do_load(input int sel, input logic [7:0] pmask, input logic [1:0] pcmd,
                         input string nm);
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    step();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = pmask[i];
      cmd       = pcmd;
      datain    = sample(sel, i);
      chk($sformatf("%s_busy%0d", nm, i), busy, 1);
      step();
    end
    cmd_valid = 1'b0;
    chk({nm, "_done_busy"}, busy, 0);
  endtask

  task automatic do_burst(input logic [1:0] c, input logic [1:0] o, input logic [3:0][8:0] e,
                          input logic [3:0] pmask, input logic [1:0] pcmd, input string nm);
    cmd_valid = 1'b1;
    cmd       = c;
    op        = o;
    step();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = pmask[i];
      cmd       = pcmd;
      op        = ~o;
      chk($sformatf("%s_valid%0d", nm, i), output_valid, 1);
      chk($sformatf("%s_data%0d", nm, i), dataout, e[i]);
      chk($sformatf("%s_busy%0d", nm, i), busy, 1);
      step();
    end
    cmd_valid = 1'b0;
    chk({nm, "_end_valid"}, output_valid, 0);
    chk({nm, "_end_busy"}, busy, 0);
    chk({nm, "_end_data"}, dataout, 0);
  endtask

  task automatic try_reject(input logic [1:0] c, input string nm);
    cmd_valid = 1'b1;
    cmd       = c;
    op        = 2'b00;
    step();
    cmd_valid = 1'b0;
    chk({nm, "_valid"}, output_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    step();
    chk({nm, "_valid2"}, output_valid, 0);
  endtask

  initial begin
    reset     = 1'b1;
    datain    = '0;
    cmd       = '0;
    cmd_valid = 1'b0;
    op        = '0;

    vt[0] = mk(1, 8'b0000_1000, 2'b01, 2'b00, 9'd11,  9'd22,  9'd33,  9'd44,  4'b0000, 2'b11);
    vt[1] = mk(0, 8'h00,        2'b10, 2'b01, 9'd36,  9'd27,  9'd18,  9'd9,   4'b1001, 2'b00);
    vt[2] = mk(0, 8'h00,        2'b01, 2'b10, 9'd10,  9'd20,  9'd30,  9'd40,  4'b0110, 2'b11);
    vt[3] = mk(0, 8'h00,        2'b10, 2'b11, 9'd36,  9'd27,  9'd18,  9'd9,   4'b0000, 2'b00);
    vt[4] = mk(2, 8'b1000_0001, 2'b01, 2'b01, 9'h101, 9'h101, 9'h101, 9'h101, 4'b0000, 2'b01);
    vt[5] = mk(0, 8'h00,        2'b01, 2'b11, 9'd255, 9'd255, 9'd255, 9'd255, 4'b0000, 2'b00);
    vt[6] = mk(0, 8'h00,        2'b10, 2'b10, 9'd255, 9'd255, 9'd255, 9'd255, 4'b0000, 2'b00);
    vt[7] = mk(3, 8'h00,        2'b01, 2'b00, 9'h1FE, 9'h1FE, 9'h1FE, 9'h1FE, 4'b0000, 2'b00);
    vt[8] = mk(1, 8'h00,        2'b10, 2'b00, 9'd44,  9'd33,  9'd22,  9'd11,  4'b0000, 2'b00);

    repeat (3) step();
    chk("rst_data", dataout, 0);
    chk("rst_valid", output_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    try_reject(2'b01, "rej_fifo_after_reset");
    try_reject(2'b10, "rej_lifo_after_reset");

    for (int n = 0; n < 9; n++) begin
      if (vt[n].ld != 0) do_load(vt[n].ld, vt[n].lpoke, 2'b11, $sformatf("v%0d_load", n));
      do_burst(vt[n].c, vt[n].o, vt[n].e, vt[n].bpoke, vt[n].pcmd, $sformatf("v%0d", n));
    end

    // CLEAR: one busy cycle, then reads are rejected.
    cmd_valid = 1'b1;
    cmd       = 2'b11;
    step();
    cmd_valid = 1'b0;
    chk("clear_busy", busy, 1);
    step();
    chk("clear_done_busy", busy, 0);
    try_reject(2'b01, "rej_fifo_after_clear");

    // Full load, then reset after 5 samples of a second load.
    do_load(1, 8'h00, 2'b00, "pre_abort_load");
    cmd_valid = 1'b1;
    cmd       = 2'b00;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      datain = sample(3, i);
      step();
    end
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", output_valid, 0);
    chk("abort_data", dataout, 0);
    step();
    chk("abort_busy_next", busy, 0);
    reset = 1'b0;
    step();
    try_reject(2'b01, "rej_fifo_after_abort");

    // Reload after abort still works.
    do_load(2, 8'h00, 2'b00, "post_abort_load");
    do_burst(2'b01, 2'b00, {9'd255, 9'd255, 9'd255, 9'd255}, 4'b0000, 2'b00, "post_abort_add");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
